rv32i_cpu: RTL and testbench

RV32I_CPU -- requirements
Module: rv32i_cpu

---
 rtl/rv32i_pkg.sv | 62 ++++++
 rtl/rv32i_cpu_regfile.sv | 33 +++
 rtl/rv32i_cpu.sv | 113 +++++++++++
 tb/tb_rv32i_cpu.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I encodings, ALU op enum and ALU evaluation.
// Imported by the top-level core and its register file.
package rv32i_pkg;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND
  } alu_op_e;

  typedef struct packed {
    alu_op_e op;
    logic    use_imm;
    logic    we;
  } dec_t;

  function automatic logic [31:0] alu_eval(
    input alu_op_e     op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [31:0] r;
    r = 32'd0;
    case (op)
      ALU_ADD:  r = a + b;
      ALU_SUB:  r = a - b;
      ALU_SLL:  r = a << b[4:0];
      ALU_SLT:  r = {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU: r = {31'd0, a < b};
      ALU_XOR:  r = a ^ b;
      ALU_SRL:  r = a >> b[4:0];
      ALU_SRA:  r = $signed(a) >>> b[4:0];
      ALU_OR:   r = a | b;
      ALU_AND:  r = a & b;
      default:  r = 32'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rv32i_cpu_regfile.sv
// 32x32 register file, two async read ports, one write port.
// Ports: clk/rst_n, rs1_i/rs2_i -> rd1_o/rd2_o, we_i/rd_i/wd_i write.
module regfile
  import rv32i_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  output logic [31:0] rd1_o,
  output logic [31:0] rd2_o,
  input  logic        we_i,
  input  logic [4:0]  rd_i,
  input  logic [31:0] wd_i
);

  logic [31:0] regs_q [32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= 32'd0;
      end
    end else if (we_i && (rd_i != 5'd0)) begin
      regs_q[rd_i] <= wd_i;
    end
  end

  // x0 is forced at the read port as well as never written
  assign rd1_o = (rs1_i == 5'd0) ? 32'd0 : regs_q[rs1_i];
  assign rd2_o = (rs2_i == 5'd0) ? 32'd0 : regs_q[rs2_i];

endmodule

// File: rtl/rv32i_cpu.sv
// Single-cycle RV32I integer core (OP, OP-IMM only, no branches).
// Ports: clk, rst_n, instruction in, PC_out and LED out.
module rv32i_cpu
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instruction,
  output logic [31:0] PC_out,
  output logic [7:0]  LED
);

  logic [31:0] pc_q, pc_d;
  logic [7:0]  led_q, led_d;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm;
  logic [31:0] rs1_val, rs2_val;
  logic [31:0] op_b;
  logic [31:0] result;
  dec_t        dec;

  assign opcode = instruction[6:0];
  assign rd     = instruction[11:7];
  assign funct3 = instruction[14:12];
  assign rs1    = instruction[19:15];
  assign rs2    = instruction[24:20];
  assign funct7 = instruction[31:25];
  assign imm    = {{20{instruction[31]}}, instruction[31:20]};

  always_comb begin
    dec = '{op: ALU_ADD, use_imm: 1'b0, we: 1'b0};
    unique case (1'b1)
      (opcode == OPC_OP_IMM): begin
        dec.use_imm = 1'b1;
        dec.we      = 1'b1;
        case (funct3)
          F3_ADD:  dec.op = ALU_ADD;
          F3_SLT:  dec.op = ALU_SLT;
          F3_SLTU: dec.op = ALU_SLTU;
          F3_XOR:  dec.op = ALU_XOR;
          F3_OR:   dec.op = ALU_OR;
          F3_AND:  dec.op = ALU_AND;
          F3_SLL: begin
            dec.op = ALU_SLL;
            dec.we = (funct7 == F7_BASE);
          end
          default: begin
            // F3_SR: instr[30] picks arithmetic
            dec.op = funct7[5] ? ALU_SRA : ALU_SRL;
            dec.we = (funct7 == F7_BASE) ||
                     (funct7 == F7_ALT);
          end
        endcase
      end
      (opcode == OPC_OP): begin
        case (funct3)
          F3_ADD:  dec.op = funct7[5] ? ALU_SUB : ALU_ADD;
          F3_SLL:  dec.op = ALU_SLL;
          F3_SLT:  dec.op = ALU_SLT;
          F3_SLTU: dec.op = ALU_SLTU;
          F3_XOR:  dec.op = ALU_XOR;
          F3_SR:   dec.op = funct7[5] ? ALU_SRA : ALU_SRL;
          F3_OR:   dec.op = ALU_OR;
          default: dec.op = ALU_AND;
        endcase
        // alt funct7 only legal for SUB and SRA
        dec.we = (funct7 == F7_BASE) ||
                 ((funct7 == F7_ALT) &&
                  ((funct3 == F3_ADD) ||
                   (funct3 == F3_SR)));
      end
      default: ;
    endcase
  end

  assign op_b   = dec.use_imm ? imm : rs2_val;
  assign result = alu_eval(dec.op, rs1_val, op_b);

  assign pc_d  = pc_q + 32'd4;
  assign led_d = dec.we ? result[7:0] : led_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= RESET_PC;
      led_q <= 8'h00;
    end else begin
      pc_q  <= pc_d;
      led_q <= led_d;
    end
  end

  regfile u_rf (
    .clk   (clk),
    .rst_n (rst_n),
    .rs1_i (rs1),
    .rs2_i (rs2),
    .rd1_o (rs1_val),
    .rd2_o (rs2_val),
    .we_i  (dec.we),
    .rd_i  (rd),
    .wd_i  (result)
  );

  assign PC_out = pc_q;
  assign LED    = led_q;

endmodule

// File: tb/tb_rv32i_cpu.sv
// Scoreboard bench for rv32i_cpu: expected commits queued at issue.
// Checks PC_out, LED and the destination register after each edge.
module tb_rv32i_cpu;

  logic        clk;
  logic        rst_n;
  logic [31:0] instruction;
  logic [31:0] PC_out;
  logic [7:0]  LED;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] val;
    logic [7:0]  led;
    logic [31:0] pc;
    string       name;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] pc_m;
  int          checks;
  int          errors;

  rv32i_cpu dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instruction (instruction),
    .PC_out      (PC_out),
    .LED         (LED)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // drive one instruction, queue its expected commit, retire it
  task automatic step(
    input string       name,
    input logic [31:0] ins,
    input logic [4:0]  rd,
    input logic [31:0] val,
    input logic [7:0]  led
  );
    exp_t e;
    instruction = ins;
    pc_m = pc_m + 32'd4;
    sb.push_back('{rd, val, led, pc_m, name});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    checks++;
    if (PC_out !== e.pc) begin
      errors++;
      $display("FAIL %s pc: got %h want %h",
               e.name, PC_out, e.pc);
    end
    checks++;
    if (LED !== e.led) begin
      errors++;
      $display("FAIL %s led: got %h want %h",
               e.name, LED, e.led);
    end
    checks++;
    if (dut.u_rf.regs_q[e.rd] !== e.val) begin
      errors++;
      $display("FAIL %s x%0d: got %h want %h", e.name,
               e.rd, dut.u_rf.regs_q[e.rd], e.val);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    instruction = 32'h0000_0013;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (PC_out !== 32'h0) begin
      errors++;
      $display("FAIL reset pc: got %h want 0", PC_out);
    end
    checks++;
    if (LED !== 8'h00) begin
      errors++;
      $display("FAIL reset led: got %h want 00", LED);
    end
    rst_n = 1'b1;
    pc_m = 32'h0;
  endtask

  task automatic test_addi;
    step("addi", 32'h0226_8193, 5'd3, 32'd34, 8'h22);
  endtask

  task automatic test_logic;
    step("xori", 32'h04CF_4A13, 5'd20, 32'd76, 8'h4C);
    step("andi", 32'h015A_7493, 5'd9, 32'd4, 8'h04);
  endtask

  task automatic test_shift;
    step("slli", 32'h0094_9893, 5'd17, 32'd2048, 8'h00);
    step("srli", 32'h0028_D913, 5'd18, 32'd512, 8'h00);
  endtask

  task automatic test_signed;
    step("addi_m1", 32'hFFF0_0293, 5'd5,
         32'hFFFF_FFFF, 8'hFF);
    step("srai", 32'h4042_D313, 5'd6,
         32'hFFFF_FFFF, 8'hFF);
    step("srli_neg", 32'h0042_D313, 5'd6,
         32'h0FFF_FFFF, 8'hFF);
    step("sltiu", 32'h0012_B393, 5'd7, 32'd0, 8'h00);
    step("slti", 32'h0012_A393, 5'd7, 32'd1, 8'h01);
  endtask

  task automatic test_regop;
    step("sub", 32'h4032_8433, 5'd8,
         32'hFFFF_FFDD, 8'hDD);
    step("slt", 32'h0032_A533, 5'd10, 32'd1, 8'h01);
    step("sltu", 32'h0032_B5B3, 5'd11, 32'd0, 8'h00);
    step("sra", 32'h4092_D633, 5'd12,
         32'hFFFF_FFFF, 8'hFF);
    step("add", 32'h0094_06B3, 5'd13,
         32'hFFFF_FFE1, 8'hE1);
    step("illegal_f7", 32'h0232_8433, 5'd8,
         32'hFFFF_FFDD, 8'hE1);
  endtask

  task automatic test_x0_nop;
    step("addi_x0", 32'h0050_0013, 5'd0, 32'd0, 8'h05);
    step("ecall_nop", 32'h0000_0073, 5'd3, 32'd34, 8'h05);
  endtask

  task automatic test_reset_mid;
    int bad;
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (PC_out !== 32'h0) begin
      errors++;
      $display("FAIL midrst pc: got %h want 0", PC_out);
    end
    checks++;
    if (LED !== 8'h00) begin
      errors++;
      $display("FAIL midrst led: got %h want 00", LED);
    end
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      if (dut.u_rf.regs_q[i] !== 32'd0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL midrst regs: got %0d nonzero want 0",
               bad);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    pc_m = 32'h0;
    step("resume", 32'h0226_8193, 5'd3, 32'd34, 8'h22);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    pc_m = 32'h0;
    test_reset();
    test_addi();
    test_logic();
    test_shift();
    test_signed();
    test_regop();
    test_x0_nop();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard: got %0d left want 0",
               sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
